muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters SHALL be none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request an operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 a  input  32  operand A (register-file rd1): multiplicand or dividend.
REQ-007 b  input  32  operand B (register-file rd2): multiplier or divisor.
REQ-008 we_hi  input  1  MTHI strobe; writes wd into hi.
REQ-009 we_lo  input  1  MTLO strobe; writes wd into lo.
REQ-010 wd  input  32  MTHI/MTLO write data.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse, high in the cycle new hi/lo first become visible.
REQ-013 hi  output  32  HI register (product upper word, or remainder).
REQ-014 lo  output  32  LO register (product lower word, or quotient).

Function
REQ-015 FSM SHALL have states IDLE, RUN, FIX; only legal transitions: IDLE->RUN, RUN->FIX, FIX->IDLE.
REQ-016 IDLE: on edge with start=1, SHALL latch op, |a| and |b| (signed ops) or a and b (unsigned ops), plus both operand signs; clear 6-bit iteration counter; go to RUN; busy=1 after that edge.
REQ-017 RUN: SHALL perform exactly one iteration per cycle for 32 cycles; multiply = shift-add on 64-bit accumulator; divide = restoring shift-subtract on 33-bit partial remainder.
REQ-018 RUN SHALL exit to FIX on the edge completing iteration 31 (counter 31).
REQ-019 FIX: SHALL apply sign correction and on the next edge write hi/lo, pulse done=1, drop busy=0, and return to IDLE.
REQ-020 Latency: start sampled at edge k -> hi/lo updated, done=1, busy=0 after edge k+34; busy=1 after edges k..k+33.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the exact 64-bit signed/unsigned product.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with sign of dividend; for all b!=0, a = lo*b + hi.
REQ-023 Divide by zero (b=0, DIV or DIVU): SHALL yield hi=a unmodified, lo=32'hFFFFFFFF; no error flag; latency unchanged.
REQ-024 DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): SHALL yield lo=32'h80000000, hi=0.
REQ-025 start while busy=1 SHALL be ignored; no queueing; the in-flight operation is unaffected.
REQ-026 start in the same cycle done=1 (state IDLE) SHALL be accepted normally.
REQ-027 we_hi/we_lo in IDLE SHALL write wd on that edge; both high SHALL write wd into both registers.
REQ-028 we_hi/we_lo while busy=1 SHALL be dropped; hi/lo SHALL hold their pre-operation values until the completion edge.
REQ-029 start and we_hi/we_lo together in IDLE: MT write SHALL take effect on that edge; the operation result SHALL overwrite it at completion.
REQ-030 hi/lo SHALL be directly registered outputs, no combinational path from any input.
REQ-031 op and operands SHALL be latched once; changes to a, b, op during RUN/FIX SHALL have no effect.

Reset
REQ-032 reset=1 at any edge SHALL force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0; reset has priority over start and we_hi/we_lo.
REQ-033 Reset asserted mid-RUN or in FIX SHALL abort the operation; no done pulse SHALL follow; start accepted on the first edge after reset deasserts.

Verification
REQ-034 MULT a=32'hFFFFFFFD (-3), b=7 -> after 34 edges hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse exactly 1 cycle.
REQ-035 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-036 DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-037 DIVU a=5, b=0 -> hi=5, lo=32'hFFFFFFFF; second start at cycle k+10 ignored, busy falls exactly after edge k+34.
REQ-038 MTHI wd=32'h1234 in IDLE -> hi=32'h1234 next edge; MTLO during busy -> lo unchanged until result written.
REQ-039 Reset at cycle k+20 of a MULT -> hi=lo=0, busy=0, no done; new MULTU 3x4 afterward -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and data bundle between a pipeline (master) and the multiply/divide unit (slave).
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Operands are reduced to magnitudes on start, processed for 32 cycles
// (shift-add or restoring shift-subtract), then sign-corrected in FIX.
module muldiv_unit (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic        is_div_q;
    logic        sa_q, sb_q;
    logic [31:0] opnd_q;      // multiplicand (mult) or divisor (div), as magnitude
    logic [63:0] acc_q;       // {upper/remainder, multiplier/dividend-quotient}
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    // Operand preparation at start: signed ops take magnitudes, unsigned pass through.
    logic        is_signed_in, sa_in, sb_in;
    logic [31:0] a_mag_in, b_mag_in;

    assign is_signed_in = ~bus.op[0];
    assign sa_in        = is_signed_in & bus.a[31];
    assign sb_in        = is_signed_in & bus.b[31];
    assign a_mag_in     = sa_in ? (32'd0 - bus.a) : bus.a;
    assign b_mag_in     = sb_in ? (32'd0 - bus.b) : bus.b;

    // One shift-add step: conditionally add multiplicand to the upper half, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // One restoring divide step: shift in the next dividend bit, subtract if it fits.
    // The remainder after a successful subtract is below the divisor, so 32 bits hold it.
    logic [32:0] div_part;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;

    assign div_part = {acc_q[63:32], acc_q[31]};
    assign div_ge   = (div_part >= {1'b0, opnd_q});
    assign div_rem  = div_ge ? (div_part[31:0] - opnd_q) : div_part[31:0];
    assign div_next = {div_rem, acc_q[30:0], div_ge};

    // Sign correction of the magnitude result; divide by zero forces an all-ones quotient.
    logic [63:0] fix_val;
    logic        neg_res;

    assign neg_res = sa_q ^ sb_q;

    // Final result selection for the FIX stage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fix_val = acc_q;
        if (is_div_q) begin
            fix_val[63:32] = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            if (opnd_q == 32'd0)
                fix_val[31:0] = 32'hFFFF_FFFF;
            else if (neg_res)
                fix_val[31:0] = 32'd0 - acc_q[31:0];
        end else if (neg_res) begin
            fix_val = 64'd0 - acc_q;
        end
    end

    // Next-state logic. FIX spans two cycles: correct the result, then publish it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)          state_d = RUN;
            RUN:     if (cnt_q == 6'd31)     state_d = FIX;
            FIX:     if (cnt_q == 6'd1)      state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath, counter and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 6'd0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.we_hi) hi_q <= bus.wd;
                    if (bus.we_lo) lo_q <= bus.wd;
                    if (bus.start) begin
                        cnt_q    <= 6'd0;
                        is_div_q <= bus.op[1];
                        sa_q     <= sa_in;
                        sb_q     <= sb_in;
                        opnd_q   <= bus.op[1] ? b_mag_in : a_mag_in;
                        acc_q    <= {32'd0, (bus.op[1] ? a_mag_in : b_mag_in)};
                    end
                end
                RUN: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                end
                FIX: begin
                    if (cnt_q == 6'd0) begin
                        acc_q <= fix_val;
                        cnt_q <= 6'd1;
                    end else begin
                        hi_q   <= acc_q[63:32];
                        lo_q   <= acc_q[31:0];
                        done_q <= 1'b1;
                        cnt_q  <= 6'd0;
                    end
                end
                default: cnt_q <= 6'd0;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random operations,
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic        prev_done;
    logic [31:0] exp_hi, exp_lo;

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact products, truncating division, remainder follows dividend,
    // divide by zero returns {a, all-ones}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa64, sb64, q, r;
        logic [63:0] res;
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        case (op)
            2'b00: res = sa64 * sb64;
            2'b01: res = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa64 / sb64;
                    r = sa64 % sb64;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Monitor: every done pulse must be single-cycle and match the oldest expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            check("done_single_cycle", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=hi:%h_lo:%h required=no_done", bus.hi, bus.lo);
            end else begin
                exp_v = exp_q.pop_front();
                check("result_hilo", {bus.hi, bus.lo}, exp_v);
            end
        end
        prev_done = bus.done;
    end

    // mode 0: plain; 1: stray start + MT writes while busy; 2: reset at k+20; 3: MTHI with start.
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [63:0] r;
        logic        aborted;
        r = model(op, a, b);
        aborted = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (mode == 3) begin
            bus.we_hi = 1'b1;
            bus.wd    = 32'hCAFE_0001;
        end
        if (mode != 2) exp_q.push_back(r);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.we_hi = 1'b0;
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        if (mode == 3) begin
            exp_hi = 32'hCAFE_0001;
            check("mt_with_start_hi", {32'd0, bus.hi}, {32'd0, exp_hi});
        end
        bus.op = 2'($urandom);
        bus.a  = $urandom;
        bus.b  = $urandom;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk); #1;
            if (mode == 1 && e == 9) begin
                bus.start = 1'b1;
                bus.we_lo = 1'b1;
                bus.we_hi = 1'b1;
                bus.wd    = $urandom;
            end
            if (mode == 1 && e == 10) begin
                bus.start = 1'b0;
                bus.we_lo = 1'b0;
                bus.we_hi = 1'b0;
                check("busy_mt_dropped", {bus.hi, bus.lo}, {exp_hi, exp_lo});
            end
            if (mode == 2 && e == 19) reset = 1'b1;
            if (mode == 2 && e == 20) begin
                reset = 1'b0;
                check("abort_state", {bus.hi, bus.lo}, 64'd0);
                check("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
                exp_hi = 32'd0;
                exp_lo = 32'd0;
                aborted = 1'b1;
                break;
            end
            if (e == 33) begin
                check("busy_before_done", {62'd0, bus.busy, bus.done}, 64'd2);
                check("hilo_held", {bus.hi, bus.lo}, {exp_hi, exp_lo});
            end
            if (e == 34) begin
                check("done_edge_k34", {62'd0, bus.busy, bus.done}, 64'd1);
                exp_hi = r[63:32];
                exp_lo = r[31:0];
            end
        end
        if (aborted) repeat (40) @(posedge clk);
    endtask

    task automatic mt(input logic whi, input logic wlo, input logic [31:0] wd);
        @(negedge clk);
        bus.we_hi = whi;
        bus.we_lo = wlo;
        bus.wd    = wd;
        @(posedge clk); #1;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        if (whi) exp_hi = wd;
        if (wlo) exp_lo = wd;
        check("mt_write", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        checks    = 0;
        errors    = 0;
        prev_done = 1'b0;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wd    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        reset = 1'b0;

        run(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(2'b11, 32'd100, 32'd7, 0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(2'b11, 32'd5, 32'd0, 1);
        run(2'b10, 32'hFFFF_FFF9, 32'd0, 0);
        mt(1'b1, 1'b0, 32'h0000_1234);
        mt(1'b0, 1'b1, 32'h0000_5678);
        mt(1'b1, 1'b1, 32'hABCD_0000);
        run(2'b00, 32'h0001_2345, 32'hFFFF_FFF7, 3);
        run(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 2);
        run(2'b01, 32'd3, 32'd4, 0);
        run(2'b10, 32'h8000_0000, 32'd1, 0);

        for (int i = 0; i < 25; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            run(rop, ra, rb, (i % 7 == 3) ? 1 : 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
